// File: rtl/iob_2p_assim_fifo_ctrl_if.sv
// Push/pop handshake and memory-port bundle for the asymmetric FIFO controller.
// The controller takes the slave modport. The producer/consumer/memory side takes the master modport.
interface iob_2p_assim_fifo_ctrl_if #(
  parameter int unsigned W_DATA_W = 32,
  parameter int unsigned R_DATA_W = 16,
  parameter int unsigned W_ADDR_W = 10
);
  localparam int unsigned RATIO    = W_DATA_W / R_DATA_W;
  localparam int unsigned R_ADDR_W = W_ADDR_W + $clog2(RATIO);

  logic                push;
  logic [W_DATA_W-1:0] push_data;
  logic                full;
  logic                overflow;
  logic                pop;
  logic [R_DATA_W-1:0] pop_data;
  logic                pop_valid;
  logic                empty;
  logic                underflow;
  logic [R_ADDR_W:0]   level;
  logic                mem_w_en;
  logic [W_ADDR_W-1:0] mem_w_addr;
  logic [W_DATA_W-1:0] mem_w_data;
  logic                mem_r_en;
  logic [R_ADDR_W-1:0] mem_r_addr;
  logic [R_DATA_W-1:0] mem_r_data;

  modport slave (
    input  push, push_data, pop, mem_r_data,
    output full, overflow, pop_data, pop_valid, empty, underflow, level,
           mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
  );

  modport master (
    output push, push_data, pop, mem_r_data,
    input  full, overflow, pop_data, pop_valid, empty, underflow, level,
           mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
  );
endinterface

// File: rtl/iob_2p_assim_fifo_ctrl.sv
// Wide-in / narrow-out FIFO controller driving an external two-port asymmetric memory.
// The level counts narrow slots, so a wide word may be consumed partially.
module iob_2p_assim_fifo_ctrl #(
  parameter int unsigned W_DATA_W = 32,
  parameter int unsigned R_DATA_W = 16,
  parameter int unsigned W_ADDR_W = 10
) (
  input logic                    clk,
  input logic                    rst,
  iob_2p_assim_fifo_ctrl_if.slave io
);
  localparam int unsigned RATIO    = W_DATA_W / R_DATA_W;
  localparam int unsigned R_ADDR_W = W_ADDR_W + $clog2(RATIO);
  localparam int unsigned LVL_W    = R_ADDR_W + 1;
  localparam logic [LVL_W-1:0] FULL_THR = LVL_W'((2 ** R_ADDR_W) - RATIO);
  localparam logic [LVL_W-1:0] RATIO_L  = LVL_W'(RATIO);

  logic [W_ADDR_W-1:0] wptr;
  logic [R_ADDR_W-1:0] rptr;
  logic [LVL_W-1:0]    level;
  logic                pop_valid;
  logic                overflow;
  logic                underflow;

  logic                empty;
  logic                full;
  logic                push_acc;
  logic                pop_acc;
  logic [LVL_W-1:0]    level_nxt;

  // Flags from the registered level; acceptance and next level from them.
  always_comb begin
    empty     = (level == '0);
    full      = (level > FULL_THR);
    push_acc  = io.push & ~full;
    pop_acc   = io.pop & ~empty;
    level_nxt = level;
    if (push_acc) level_nxt = level_nxt + RATIO_L;
    if (pop_acc)  level_nxt = level_nxt - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wptr <= wptr + W_ADDR_W'(1);
      if (pop_acc)  rptr <= rptr + R_ADDR_W'(1);
      level     <= level_nxt;
      pop_valid <= pop_acc;
      overflow  <= io.push & full;
      underflow <= io.pop & empty;
    end
  end

  // Memory ports are direct; read data passes through with the memory's own register.
  assign io.mem_w_en   = push_acc;
  assign io.mem_w_addr = wptr;
  assign io.mem_w_data = io.push_data;
  assign io.mem_r_en   = pop_acc;
  assign io.mem_r_addr = rptr;

  assign io.pop_data  = io.mem_r_data;
  assign io.pop_valid = pop_valid;
  assign io.full      = full;
  assign io.empty     = empty;
  assign io.overflow  = overflow;
  assign io.underflow = underflow;
  assign io.level     = level;
endmodule

// File: tb/tb_iob_2p_assim_fifo_ctrl.sv
// Bench for iob_2p_assim_fifo_ctrl: queue-based FIFO model checked every cycle,
// plus directed literal expectations, with a behavioural asymmetric memory alongside.
module tb_iob_2p_assim_fifo_ctrl;
  localparam int unsigned W_DATA_W = 32;
  localparam int unsigned R_DATA_W = 16;
  localparam int unsigned W_ADDR_W = 10;
  localparam int unsigned RATIO    = W_DATA_W / R_DATA_W;
  localparam int unsigned R_ADDR_W = W_ADDR_W + $clog2(RATIO);
  localparam int unsigned CAP      = 2 ** R_ADDR_W;
  localparam int unsigned WDEPTH   = 2 ** W_ADDR_W;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  iob_2p_assim_fifo_ctrl_if #(.W_DATA_W(W_DATA_W), .R_DATA_W(R_DATA_W), .W_ADDR_W(W_ADDR_W)) io ();

  iob_2p_assim_fifo_ctrl #(.W_DATA_W(W_DATA_W), .R_DATA_W(R_DATA_W), .W_ADDR_W(W_ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  // Asymmetric memory: wide write, registered narrow little-endian read.
  logic [W_DATA_W-1:0] mem [WDEPTH];
  always @(posedge clk) begin
    if (io.mem_w_en) mem[io.mem_w_addr] <= io.mem_w_data;
    if (io.mem_r_en)
      io.mem_r_data <= mem[io.mem_r_addr[R_ADDR_W-1:1]][int'(io.mem_r_addr[0])*R_DATA_W +: R_DATA_W];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of narrow words in FIFO order plus counts of accepted transfers.
  logic [R_DATA_W-1:0] q[$];
  int                  wcnt = 0;
  int                  rcnt = 0;
  logic                exp_pv = 1'b0;
  logic [R_DATA_W-1:0] exp_pd = '0;
  logic                exp_ov = 1'b0;
  logic                exp_uf = 1'b0;

  initial begin
    forever begin
      int lvl;
      logic m_full, m_empty, pa, pp;
      @(negedge clk);
      #2;
      lvl     = q.size();
      m_empty = (lvl == 0);
      m_full  = (lvl > int'(CAP - RATIO));
      pa      = io.push && !m_full;
      pp      = io.pop && !m_empty;
      chk("level", 64'(io.level), 64'(lvl));
      chk("empty", 64'(io.empty), 64'(m_empty));
      chk("full", 64'(io.full), 64'(m_full));
      chk("overflow", 64'(io.overflow), 64'(exp_ov));
      chk("underflow", 64'(io.underflow), 64'(exp_uf));
      chk("pop_valid", 64'(io.pop_valid), 64'(exp_pv));
      if (exp_pv) chk("pop_data", 64'(io.pop_data), 64'(exp_pd));
      chk("mem_w_en", 64'(io.mem_w_en), 64'(pa));
      if (pa) begin
        chk("mem_w_addr", 64'(io.mem_w_addr), 64'(wcnt % WDEPTH));
        chk("mem_w_data", 64'(io.mem_w_data), 64'(io.push_data));
      end
      chk("mem_r_en", 64'(io.mem_r_en), 64'(pp));
      if (pp) chk("mem_r_addr", 64'(io.mem_r_addr), 64'(rcnt % CAP));
      if (rst) begin
        q.delete();
        wcnt = 0; rcnt = 0;
        exp_pv = 1'b0; exp_ov = 1'b0; exp_uf = 1'b0;
      end else begin
        exp_ov = io.push && m_full;
        exp_uf = io.pop && m_empty;
        exp_pv = pp;
        if (pp) begin
          exp_pd = q.pop_front();
          rcnt++;
        end
        if (pa) begin
          for (int k = 0; k < int'(RATIO); k++) q.push_back(io.push_data[k*R_DATA_W +: R_DATA_W]);
          wcnt++;
        end
      end
    end
  end

  task automatic step(input logic r, input logic pu, input logic [W_DATA_W-1:0] d, input logic po);
    @(negedge clk);
    rst          = r;
    io.push      = pu;
    io.push_data = d;
    io.pop       = po;
  endtask

  initial begin
    rst = 1'b1; io.push = 1'b0; io.push_data = '0; io.pop = 1'b0;
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    step(0, 0, '0, 0);
    #3;
    chk("rst_level", 64'(io.level), 64'd0);
    chk("rst_empty", 64'(io.empty), 64'd1);
    chk("rst_full", 64'(io.full), 64'd0);
    chk("rst_pop_valid", 64'(io.pop_valid), 64'd0);
    chk("rst_overflow", 64'(io.overflow), 64'd0);
    chk("rst_underflow", 64'(io.underflow), 64'd0);

    // One wide word, two narrow pops, low lane first.
    step(0, 1, 32'hBBBBAAAA, 0);
    step(0, 0, '0, 1);
    #3 chk("lane_level2", 64'(io.level), 64'd2);
    step(0, 0, '0, 1);
    #3;
    chk("lane_level1", 64'(io.level), 64'd1);
    chk("lane0_valid", 64'(io.pop_valid), 64'd1);
    chk("lane0_data", 64'(io.pop_data), 64'hAAAA);
    step(0, 0, '0, 0);
    #3;
    chk("lane_level0", 64'(io.level), 64'd0);
    chk("lane1_valid", 64'(io.pop_valid), 64'd1);
    chk("lane1_data", 64'(io.pop_data), 64'hBBBB);
    chk("lane_empty", 64'(io.empty), 64'd1);

    // Fill to full from a fresh reset, then overflow.
    step(1, 0, '0, 0);
    for (int i = 0; i < int'(WDEPTH); i++) step(0, 1, {16'(i + 16'h100), 16'(i)}, 0);
    step(0, 1, 32'hDEADBEEF, 0);
    #3;
    chk("fill_level", 64'(io.level), 64'd2048);
    chk("fill_full", 64'(io.full), 64'd1);
    chk("fill_w_en", 64'(io.mem_w_en), 64'd0);
    step(0, 0, '0, 1);
    #3;
    chk("ovf_pulse", 64'(io.overflow), 64'd1);
    chk("ovf_level", 64'(io.level), 64'd2048);
    step(0, 0, '0, 0);
    #3;
    chk("pop1_level", 64'(io.level), 64'd2047);
    chk("pop1_full", 64'(io.full), 64'd1);
    chk("ovf_clear", 64'(io.overflow), 64'd0);
    chk("pop1_data", 64'(io.pop_data), 64'h0000);
    step(0, 0, '0, 1);
    step(0, 1, 32'h13579BDF, 0);
    #3;
    chk("pop2_level", 64'(io.level), 64'd2046);
    chk("pop2_full", 64'(io.full), 64'd0);
    chk("wrap_w_en", 64'(io.mem_w_en), 64'd1);
    chk("wrap_w_addr", 64'(io.mem_w_addr), 64'd0);
    chk("pop2_data", 64'(io.pop_data), 64'h0100);

    // Underflow, then simultaneous push/pop on empty.
    step(1, 0, '0, 0);
    step(0, 0, '0, 1);
    #3;
    chk("uf_r_en", 64'(io.mem_r_en), 64'd0);
    step(0, 0, '0, 0);
    #3;
    chk("uf_pulse", 64'(io.underflow), 64'd1);
    chk("uf_pop_valid", 64'(io.pop_valid), 64'd0);
    step(0, 1, 32'h12345678, 1);
    #3 chk("uf_clear", 64'(io.underflow), 64'd0);
    step(0, 0, '0, 1);
    #3;
    chk("pp_level", 64'(io.level), 64'd2);
    chk("pp_underflow", 64'(io.underflow), 64'd1);
    step(0, 0, '0, 0);
    #3 chk("pp_data", 64'(io.pop_data), 64'h5678);

    // Random traffic: filling phase, reset at 1500, then draining phase.
    for (int c = 0; c < 3000; c++) begin
      logic r, pu, po;
      r  = (c == 1500);
      pu = (c < 1500) ? ($urandom_range(9) < 9) : ($urandom_range(9) < 3);
      po = (c < 1500) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 9);
      if (c == 1500) po = 1'b1;
      if (c == 1501) begin pu = 1'b0; po = 1'b1; end
      step(r, pu, W_DATA_W'($urandom), po);
      if (c == 1501) begin
        #3;
        chk("post_rst_level", 64'(io.level), 64'd0);
        chk("post_rst_pop_valid", 64'(io.pop_valid), 64'd0);
      end
      if (c == 1502) begin
        #3 chk("post_rst_underflow", 64'(io.underflow), 64'd1);
      end
    end
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iob_2p_assim_fifo_ctrl.md
Name: iob_2p_assim_fifo_ctrl

Overview:
- Asymmetric FIFO controller that drives the tiled two-port asymmetric memory.
- Each push accepts one wide word; each pop delivers one narrow word.
- The block owns the write and read pointers, the fill level, full/empty flags and error pulses. The memory itself is instantiated alongside it, not inside it.
- Used as the width-down-conversion buffer between a 32-bit producer and a 16-bit consumer.

Parameters:
- W_DATA_W, 32, push/memory write data width.
- R_DATA_W, 16, pop/memory read data width. W_DATA_W = R_DATA_W * 2**n with n >= 0.
- W_ADDR_W, 10, memory write address width, in wide words. Capacity is 2**W_ADDR_W wide words.
- RATIO, W_DATA_W/R_DATA_W, derived; do not override.
- R_ADDR_W, W_ADDR_W+$clog2(RATIO), derived memory read address width, in narrow words.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- push  in  1  write request
- push_data  in  W_DATA_W  wide word to store
- full  out  1  no room for one more wide word
- overflow  out  1  one-cycle pulse: push rejected
- pop  in  1  read request
- pop_data  out  R_DATA_W  narrow word; valid when pop_valid=1
- pop_valid  out  1  pop_data valid this cycle
- empty  out  1  no narrow word available
- underflow  out  1  one-cycle pulse: pop rejected
- level  out  R_ADDR_W+1  occupancy in narrow words, 0..2**R_ADDR_W
- mem_w_en  out  1  memory write enable
- mem_w_addr  out  W_ADDR_W  memory write address
- mem_w_data  out  W_DATA_W  memory write data
- mem_r_en  out  1  memory read enable
- mem_r_addr  out  R_ADDR_W  memory read address
- mem_r_data  in  R_DATA_W  memory read data; registered, 1-cycle latency

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state:
  - wptr=0, rptr=0, level=0.
  - empty=1, full=0, pop_valid=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
- Reset mid-operation: all state above is cleared on the reset edge. A pop issued the cycle before reset yields pop_valid=0 (reset wins).
- Flags are computed combinationally from the registered level:
  - empty = (level==0).
  - full = (level > 2**R_ADDR_W - RATIO), meaning fewer than RATIO free narrow slots.
- Push acceptance: push_acc = push & ~full.
  - mem_w_en=push_acc, mem_w_addr=wptr, mem_w_data=push_data, all combinational.
  - wptr increments by 1 and wraps modulo 2**W_ADDR_W.
- Pop acceptance: pop_acc = pop & ~empty.
  - mem_r_en=pop_acc, mem_r_addr=rptr, both combinational.
  - rptr increments by 1 and wraps modulo 2**R_ADDR_W.
- Lane order is little-endian. Narrow address j*RATIO+k returns bits [(k+1)*R_DATA_W-1 : k*R_DATA_W] of wide word j.
- Read latency: pop_valid is a register set to pop_acc. pop_data = mem_r_data (pass-through), valid exactly one cycle after an accepted pop. Back-to-back pops give one narrow word per cycle.
- Level update, using flags evaluated before the edge:
  - push_acc only: +RATIO.
  - pop_acc only: -1.
  - both: +RATIO-1.
  - neither: unchanged.
- Simultaneous events:
  - push and pop while empty: push accepted, pop rejected (underflow pulse). Data is poppable next cycle.
  - push and pop while full: pop accepted, push rejected (overflow pulse). No same-cycle pass-through.
- Error pulses: overflow = registered (push & full); underflow = registered (pop & empty). Each is high for exactly one cycle per rejected request. FIFO state is unaffected.
- Write-then-read ordering: a narrow word written at edge t may be popped from cycle t+1. The memory must give write-before-read at distinct addresses only. Same-address collision is impossible because empty blocks it.
- Partial wide word: the level counts narrow slots, so consumption may stop mid-word. The remaining lanes of that word stay poppable.

Test Plan:
- Reset then idle -> empty=1, full=0, level=0, pop_valid=0; all pulse outputs 0.
- Push 0xBBBBAAAA, then pop twice back-to-back -> pop_data 0xAAAA then 0xBBBB, on consecutive cycles each 1 cycle after its pop. level goes 2, 1, 0; empty=1 at the end.
- Fill with 1024 pushes (W_ADDR_W=10) -> full=1 at level=2048. A 1025th push gives overflow=1 for one cycle, level stays 2048, and mem_w_en=0.
- From full: one pop gives level=2047 with full still 1. A second pop gives level=2046 and full=0. A push on the next cycle is accepted and mem_w_addr wraps to 0.
- Pop on empty -> underflow pulse for 1 cycle, mem_r_en=0, pop_valid=0. Push and pop in the same cycle on empty -> level=2, underflow=1.
- Run 3000 random push/pop cycles with rst asserted at cycle 1500 -> data order matches a scoreboard, including pointer wrap. After reset: level=0, pop_valid=0 on the following cycle, and the next pop on empty raises underflow.
